fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory and fills the IF/ID slot.
// Latency: a word acked in cycle N appears on IF/ID after the edge ending cycle N.
// Backpressure: a stalled full slot parks one word in a skid register; the request stops there.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [6:0]  op_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  // REQ:     a request is on the bus and its response may land in the slot.
  // SKID:    one word is parked because the slot was stalled; the bus is idle.
  // DISCARD: the in-flight request belongs to a squashed path; its data is thrown away.
  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_SKID    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        slot_free;
  logic [31:0] target_pc;
  logic [31:0] fetch_pc_inc;

  // The slot can accept a new entry when it is empty or decode is consuming it.
  assign slot_free    = !valid_q || !stall_i;
  // Instructions are word-aligned, so the low bits of a target are meaningless.
  assign target_pc    = {redirect_pc_i[31:2], 2'b00};
  // Plain 32-bit add: the top word wraps around to address zero.
  assign fetch_pc_inc = fetch_pc_q + 32'd4;

  // Next-state, memory-side and IF/ID slot update logic.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            // Response is on the wrong path; drop it and start the new one.
            fetch_pc_d = target_pc;
          end else begin
            // Address must stay on the bus until the ack, so remember the
            // target and swallow the stale response first.
            pend_pc_d = target_pc;
            state_d   = S_DISCARD;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_inc;
          if (slot_free) begin
            instr_d = imem_rdata_i;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem_rdata_i;
            skid_pc_d    = fetch_pc_q;
            state_d      = S_SKID;
          end
        end else if (slot_free) begin
          // Waiting on memory: hand decode a bubble, keep the last PC.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      S_SKID: begin
        if (redirect_i) begin
          fetch_pc_d = target_pc;
          state_d    = S_REQ;
        end else if (!stall_i) begin
          instr_d = skid_instr_q;
          pc_d    = skid_pc_q;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end

      S_DISCARD: begin
        if (imem_ack_i) begin
          // A redirect arriving together with the ack is the most recent one.
          fetch_pc_d = redirect_i ? target_pc : pend_pc_q;
          state_d    = S_REQ;
        end else if (redirect_i) begin
          pend_pc_d = target_pc;
        end
        if (slot_free) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect squashes whatever is in the slot, even under a stall.
    if (redirect_i) begin
      instr_d = NOP_INSTR;
      pc_d    = pc_q;
      valid_d = 1'b0;
    end
  end

  // State registers; reset wins over every other input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc_q         <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req_o  = (state_q != S_SKID);
  assign imem_addr_o = fetch_pc_q;
  assign instr_o     = instr_q;
  assign op_o        = instr_q[6:0];
  assign pc_o        = pc_q;
  assign pc_plus4_o  = pc_q + 32'd4;
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_en;

  logic        req1, ack1, valid1;
  logic [31:0] addr1, rdata1, instr1, pc1, pcp4_1;
  logic [6:0]  op1;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, instr2, pc2, pcp4_2;
  logic [6:0]  op2;

  int checks;
  int failures;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign ack1   = req1 & ack_en;
  assign rdata1 = mem_word(addr1);
  assign ack2   = req2 & ack_en;
  assign rdata2 = mem_word(addr2);

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ack_i(ack1), .imem_rdata_i(rdata1), .instr_o(instr1), .op_o(op1),
    .pc_o(pc1), .pc_plus4_o(pcp4_1), .valid_o(valid1)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .instr_o(instr2), .op_o(op2),
    .pc_o(pc2), .pc_plus4_o(pcp4_2), .valid_o(valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_en = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", valid1); end
    checks++; if (instr1 !== 32'h13) begin failures++; $display("FAIL reset_instr got=%h exp=00000013", instr1); end
    checks++; if (op1 !== 7'h13) begin failures++; $display("FAIL reset_op got=%h exp=13", op1); end
    checks++; if (pc1 !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc1); end
    checks++; if (pcp4_1 !== 32'h4) begin failures++; $display("FAIL reset_pcp4 got=%h exp=4", pcp4_1); end
    checks++; if (req1 !== 1'b1 || addr1 !== 32'h0) begin failures++; $display("FAIL reset_req req=%0h addr=%h exp req=1 addr=0", req1, addr1); end
  endtask

  task automatic test_sequential();
    do_reset();
    ack_en = 1'b1;
    checks++; if (valid1 !== 1'b0) begin failures++; $display("FAIL seq_first_valid got=%0h exp=0", valid1); end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid1 !== 1'b1 || pc1 !== 32'(4 * i) || instr1 !== mem_word(32'(4 * i)) || pcp4_1 !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL seq_%0d valid=%0h pc=%h instr=%h pcp4=%h exp valid=1 pc=%h", i, valid1, pc1, instr1, pcp4_1, 32'(4 * i));
      end
      step();
    end
  endtask

  task automatic test_stall();
    do_reset();
    ack_en = 1'b1;
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (req1 !== 1'b0 || pc1 !== 32'h4 || instr1 !== mem_word(32'h4) || valid1 !== 1'b1 || addr1 !== 32'hC) begin
        failures++;
        $display("FAIL stall_hold_%0d req=%0h pc=%h instr=%h valid=%0h addr=%h exp req=0 pc=4 valid=1 addr=c", i, req1, pc1, instr1, valid1, addr1);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc1 !== 32'h8 || instr1 !== mem_word(32'h8) || valid1 !== 1'b1 || req1 !== 1'b1 || addr1 !== 32'hC) begin
      failures++;
      $display("FAIL stall_release pc=%h instr=%h valid=%0h req=%0h addr=%h exp pc=8 req=1 addr=c", pc1, instr1, valid1, req1, addr1);
    end
    step();
    checks++; if (pc1 !== 32'hC || instr1 !== mem_word(32'hC)) begin failures++; $display("FAIL stall_next pc=%h instr=%h exp pc=c", pc1, instr1); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    checks++; if (req1 !== 1'b1 || addr1 !== 32'h0 || valid1 !== 1'b0) begin failures++; $display("FAIL disc_wait1 req=%0h addr=%h valid=%0h exp req=1 addr=0 valid=0", req1, addr1, valid1); end
    step();
    checks++; if (addr1 !== 32'h0 || valid1 !== 1'b0) begin failures++; $display("FAIL disc_wait2 addr=%h valid=%0h exp addr=0 valid=0", addr1, valid1); end
    ack_en = 1'b1;
    step();
    ack_en = 1'b0;
    checks++; if (addr1 !== 32'h100 || valid1 !== 1'b0 || instr1 !== 32'h13) begin failures++; $display("FAIL disc_drop addr=%h valid=%0h instr=%h exp addr=100 valid=0 instr=13", addr1, valid1, instr1); end
    step();
    step();
    checks++; if (valid1 !== 1'b0 || addr1 !== 32'h100) begin failures++; $display("FAIL disc_wait_new valid=%0h addr=%h exp valid=0 addr=100", valid1, addr1); end
    ack_en = 1'b1;
    step();
    checks++; if (valid1 !== 1'b1 || pc1 !== 32'h100 || instr1 !== 32'hC0DE_0100) begin failures++; $display("FAIL disc_arrive valid=%0h pc=%h instr=%h exp valid=1 pc=100 instr=c0de0100", valid1, pc1, instr1); end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    ack_en = 1'b1;
    step();
    step();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 1'b0;
    checks++; if (valid1 !== 1'b0 || instr1 !== 32'h13 || op1 !== 7'b0010011) begin failures++; $display("FAIL rs_squash valid=%0h instr=%h op=%h exp valid=0 instr=13 op=13", valid1, instr1, op1); end
    checks++; if (addr1 !== 32'h200 || pc1 !== 32'h4) begin failures++; $display("FAIL rs_target addr=%h pc=%h exp addr=200 pc=4", addr1, pc1); end
    step();
    stall = 1'b0;
    checks++; if (valid1 !== 1'b1 || pc1 !== 32'h200 || instr1 !== 32'hC0DE_0200) begin failures++; $display("FAIL rs_refetch valid=%0h pc=%h instr=%h exp valid=1 pc=200 instr=c0de0200", valid1, pc1, instr1); end
  endtask

  task automatic test_skid_redirect();
    do_reset();
    ack_en = 1'b1;
    step();
    step();
    stall = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    redirect = 1'b0; stall = 1'b0;
    checks++; if (req1 !== 1'b1 || addr1 !== 32'h40 || valid1 !== 1'b0) begin failures++; $display("FAIL skid_redir req=%0h addr=%h valid=%0h exp req=1 addr=40 valid=0", req1, addr1, valid1); end
    step();
    checks++; if (valid1 !== 1'b1 || pc1 !== 32'h40 || instr1 !== 32'hC0DE_0040) begin failures++; $display("FAIL skid_redir_next valid=%0h pc=%h instr=%h exp valid=1 pc=40", valid1, pc1, instr1); end
  endtask

  task automatic test_skid_reset();
    do_reset();
    ack_en = 1'b1;
    step();
    step();
    stall = 1'b1;
    step();
    checks++; if (req1 !== 1'b0) begin failures++; $display("FAIL skidrst_enter req=%0h exp=0", req1); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (req1 !== 1'b1 || addr1 !== 32'h0 || valid1 !== 1'b0) begin failures++; $display("FAIL skidrst req=%0h addr=%h valid=%0h exp req=1 addr=0 valid=0", req1, addr1, valid1); end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    ack_en = 1'b1;
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_first_addr got=%h exp=fffffffc", addr2); end
    step();
    checks++; if (addr2 !== 32'h0) begin failures++; $display("FAIL wrap_second_addr got=%h exp=0", addr2); end
    checks++; if (pc2 !== 32'hFFFF_FFFC || pcp4_2 !== 32'h0 || valid2 !== 1'b1) begin failures++; $display("FAIL wrap_pcp4 pc=%h pcp4=%h valid=%0h exp pc=fffffffc pcp4=0 valid=1", pc2, pcp4_2, valid2); end
    step();
    checks++; if (pc2 !== 32'h0 || instr2 !== 32'hC0DE_0000) begin failures++; $display("FAIL wrap_next pc=%h instr=%h exp pc=0 instr=c0de0000", pc2, instr2); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_en = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_discard();
    test_redirect_stall();
    test_skid_redirect();
    test_skid_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
